// File: rtl/hex_dump_fmt_pkg.sv
// Shared definitions for the hex-dump formatter: ASCII constants and FSM encoding.
package hex_dump_fmt_pkg;

  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] ZERO    = 8'h30;
  localparam logic [7:0] UPPER_A = 8'h41;

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_OFS,
    ST_COLON,
    ST_SP0,
    ST_HI,
    ST_LO,
    ST_SEP,
    ST_CR,
    ST_LF
  } state_t;

endpackage

// File: rtl/hex_dump_fmt_nibble_to_hex.sv
// Combinational nibble to uppercase ASCII hex digit ('0'..'9', 'A'..'F').
module nibble_to_hex
  import hex_dump_fmt_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ch
);

  // Digits 0-9 map from '0', 10-15 map from 'A'
  always_comb begin
    if (nib < 4'd10) ch = ZERO + {4'h0, nib};
    else             ch = UPPER_A + {4'h0, nib} - 8'd10;
  end

endmodule

// File: rtl/hex_dump_fmt.sv
// Byte stream to ASCII hex-dump text: "OOOO: HH HH ... HH\r\n" per line.
// One character leaves per output handshake; a new byte is taken only when idle.
module hex_dump_fmt
  import hex_dump_fmt_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16,
  parameter int OFS_DIGITS     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int              LPOS_W   = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [LPOS_W-1:0] LPOS_END = LPOS_W'(BYTES_PER_LINE - 1);
  localparam logic [1:0]      DIG_END  = 2'(OFS_DIGITS - 1);

  state_t            state;
  logic [15:0]       ofs;
  logic [15:0]       line_ofs;
  logic [LPOS_W-1:0] lpos;
  logic [1:0]        dcnt;
  logic [7:0]        byte_q;
  logic              last_q;
  logic [3:0]        nib_sel;
  logic [7:0]        nib_ch;
  logic              accept;
  logic              xfer;

  // Printed offset digit; idx counts from the most-significant printed digit
  function automatic logic [3:0] ofs_digit(input logic [15:0] v, input logic [1:0] idx);
    logic [1:0] pos;
    pos = DIG_END - idx;
    return v[{pos, 2'b00} +: 4];
  endfunction

  assign in_ready = (state == ST_WAIT) && !rst;
  assign busy     = (state != ST_WAIT);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Select the nibble whose ASCII form is loaded on the coming state change
  always_comb begin
    nib_sel = byte_q[7:4];
    case (state)
      ST_WAIT: nib_sel = (lpos == '0) ? ofs_digit(ofs, 2'd0) : in_data[7:4];
      ST_OFS:  nib_sel = ofs_digit(line_ofs, dcnt + 2'd1);
      ST_HI:   nib_sel = byte_q[3:0];
      default: nib_sel = byte_q[7:4];
    endcase
  end

  nibble_to_hex u_nib (
    .nib (nib_sel),
    .ch  (nib_ch)
  );

  // Accepted byte and the offset of the line it opens
  always_ff @(posedge clk) begin
    if (accept) begin
      byte_q <= in_data;
      last_q <= in_last;
      if (lpos == '0) line_ofs <= ofs;
    end
  end

  // Formatter FSM; out_char is loaded with the character of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      ofs       <= '0;
      lpos      <= '0;
      dcnt      <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
    end else begin
      case (state)
        ST_WAIT: if (accept) begin
          out_valid <= 1'b1;
          out_char  <= nib_ch;
          ofs       <= ofs + 16'd1;
          dcnt      <= '0;
          state     <= (lpos == '0) ? ST_OFS : ST_HI;
        end
        ST_OFS: if (xfer) begin
          if (dcnt == DIG_END) begin
            state    <= ST_COLON;
            out_char <= COLON;
          end else begin
            dcnt     <= dcnt + 2'd1;
            out_char <= nib_ch;
          end
        end
        ST_COLON: if (xfer) begin
          state    <= ST_SP0;
          out_char <= SPACE;
        end
        ST_SP0: if (xfer) begin
          state    <= ST_HI;
          out_char <= nib_ch;
        end
        ST_HI: if (xfer) begin
          state    <= ST_LO;
          out_char <= nib_ch;
        end
        ST_LO: if (xfer) begin
          if (lpos == LPOS_END || last_q) begin
            state    <= ST_CR;
            out_char <= CR;
          end else begin
            state    <= ST_SEP;
            out_char <= SPACE;
          end
        end
        ST_SEP: if (xfer) begin
          lpos      <= lpos + 1'b1;
          out_valid <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_CR: if (xfer) begin
          state    <= ST_LF;
          out_char <= LF;
        end
        ST_LF: if (xfer) begin
          lpos      <= '0;
          out_valid <= 1'b0;
          state     <= ST_WAIT;
          if (last_q) ofs <= '0;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_dump_fmt.sv
// Bench for hex_dump_fmt: default instance (16 bytes/line, 4 digits) plus a
// 1 byte/line, 1 digit instance exercising line-per-byte and printed-offset wrap.
module tb_hex_dump_fmt;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data,   in_data_w;
  logic       in_valid,  in_valid_w;
  logic       in_last,   in_last_w;
  logic       in_ready,  in_ready_w;
  logic [7:0] out_char,  out_char_w;
  logic       out_valid, out_valid_w;
  logic       out_ready, out_ready_w;
  logic       busy,      busy_w;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hex_dump_fmt dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  hex_dump_fmt #(.BYTES_PER_LINE(1), .OFS_DIGITS(1)) dut_w (
    .clk(clk), .rst(rst), .in_data(in_data_w), .in_valid(in_valid_w), .in_last(in_last_w),
    .in_ready(in_ready_w), .out_char(out_char_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .busy(busy_w)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: text the dump must contain ----------------
  string      hexd = "0123456789ABCDEF";
  logic [7:0] exp_q[$];
  logic [7:0] exp_w[$];
  int         m_ofs = 0, m_lpos = 0, m_ofs_w = 0;

  task automatic push_hex(input int v, input int ndig, input bit to_w);
    for (int d = ndig - 1; d >= 0; d--) begin
      if (to_w) exp_w.push_back(hexd[(v >> (4 * d)) & 15]);
      else      exp_q.push_back(hexd[(v >> (4 * d)) & 15]);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    if (m_lpos == 0) begin
      push_hex(m_ofs, 4, 1'b0);
      exp_q.push_back(8'h3A);
      exp_q.push_back(8'h20);
    end
    push_hex(int'(b), 2, 1'b0);
    if (last || m_lpos == 15) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_lpos = 0;
    end else begin
      exp_q.push_back(8'h20);
      m_lpos++;
    end
    m_ofs = last ? 0 : (m_ofs + 1) % 65536;
  endtask

  task automatic model_byte_w(input logic [7:0] b, input bit last);
    push_hex(m_ofs_w % 16, 1, 1'b1);
    exp_w.push_back(8'h3A);
    exp_w.push_back(8'h20);
    push_hex(int'(b), 2, 1'b1);
    exp_w.push_back(8'h0D);
    exp_w.push_back(8'h0A);
    m_ofs_w = last ? 0 : (m_ofs_w + 1) % 65536;
  endtask

  // ---------------- output monitors ----------------
  int         rdy_pct = 100;
  bit         mon_en  = 1'b1;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_char;
  string      got_s = "";

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_hold", int'(out_char), int'(prev_char));
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (out_valid && out_ready) begin
        got_s = $sformatf("%s%c", got_s, out_char);
        if (exp_q.size() == 0) chk("extra_char", int'(out_char), -1);
        else                   chk("char", int'(out_char), int'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
    end else begin
      out_ready  = 1'b1;
      prev_stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    out_ready_w = 1'b1;
    if (!rst && out_valid_w) begin
      if (exp_w.size() == 0) chk("w_extra_char", int'(out_char_w), -1);
      else                   chk("w_char", int'(out_char_w), int'(exp_w.pop_front()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b, input bit last);
    int n;
    model_byte(b, last);
    @(negedge clk);
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("accept_timeout", n, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] b, input bit last);
    int n;
    model_byte_w(b, last);
    @(negedge clk);
    in_data_w  = b;
    in_last_w  = last;
    in_valid_w = 1'b1;
    n = 0;
    while (!in_ready_w && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("w_accept_timeout", n, 0);
    @(posedge clk);
    #1 in_valid_w = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  string line2;
  string t2_text;

  initial begin
    rst = 1'b1;
    in_data = 8'h00;   in_valid = 1'b0;   in_last = 1'b0;
    in_data_w = 8'h00; in_valid_w = 1'b0; in_last_w = 1'b0;
    out_ready = 1'b1;  out_ready_w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_char", int'(out_char), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single last byte
    got_s = "";
    send(8'hA5, 1'b1);
    drain("t1");
    chk("t1_text", int'(got_s == $sformatf("0000: A5%c%c", 13, 10)), 1);

    // 17 bytes across a line boundary
    got_s = "";
    for (int i = 0; i < 17; i++) send(8'(i), i == 16);
    drain("t2");
    chk("t2_len", got_s.len(), 65);
    line2 = got_s.substr(55, 64);
    chk("t2_line2", int'(line2 == $sformatf("0010: 10%c%c", 13, 10)), 1);
    t2_text = got_s;

    // Same bytes with a stalling UART
    rdy_pct = 45;
    got_s = "";
    for (int i = 0; i < 17; i++) send(8'(i), i == 16);
    drain("t3");
    chk("t3_same_text", int'(got_s == t2_text), 1);
    rdy_pct = 100;

    // Reset while the third byte's high nibble is pending
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_out_valid", int'(out_valid), 0);
    chk("t4_in_ready", int'(in_ready), 0);
    chk("t4_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ofs = 0;
    m_lpos = 0;
    got_s = "";
    mon_en = 1'b1;
    send(8'h3C, 1'b1);
    drain("t4");
    chk("t4_text", int'(got_s == $sformatf("0000: 3C%c%c", 13, 10)), 1);

    // Nibble boundaries
    got_s = "";
    send(8'h09, 1'b0);
    send(8'h0A, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h9F, 1'b1);
    drain("t6");
    chk("t6_text", int'(got_s == $sformatf("0000: 09 0A F0 9F%c%c", 13, 10)), 1);

    // Random bytes, random last markers, random stalls
    rdy_pct = 60;
    for (int i = 0; i < 48; i++)
      send(8'($urandom_range(255)), (i == 47) || ($urandom_range(7) == 0));
    drain("t7");
    rdy_pct = 100;

    // One byte per line, single printed offset digit wrapping F -> 0
    for (int i = 0; i < 20; i++) send_w(8'($urandom_range(255)), i == 19);
    begin
      int n;
      n = 0;
      while ((exp_w.size() != 0 || busy_w) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk("w_left", exp_w.size(), 0);
      chk("w_busy", int'(busy_w), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
